// File: rtl/morse_pkg.sv
// Shared Morse playback definitions: symbol codes, fixed tick counts and the player state set.
package morse_pkg;

    localparam logic [1:0] SYM_EMPTY = 2'b00;
    localparam logic [1:0] SYM_DOT   = 2'b01;
    localparam logic [1:0] SYM_DASH  = 2'b11;

    localparam int DOT_TICKS = 1;
    localparam int GAP_TICKS = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_ON,
        ST_GAP,
        ST_WGAP,
        ST_DONE
    } state_e;

    // Only dot and dash light the LED; empty and the reserved code both end the word.
    function automatic logic is_pulse(input logic [1:0] s);
        return (s == SYM_DOT) || (s == SYM_DASH);
    endfunction

endpackage

// File: rtl/morse_playback_tick_timer.sv
// Loadable down-counter timing the ON and word-gap durations; counts down while non-zero.
// expired flags the final tick of a loaded duration.
module tick_timer #(
    parameter int W = 2
) (
    input  logic         clock_1hz,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         expired
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (value_q != '0) begin
            value_d = value_q - ONE;
        end
    end

    always_ff @(posedge clock_1hz) begin
        if (!resetn) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value   = value_q;
    assign expired = (value_q == ONE);

endmodule

// File: rtl/morse_playback.sv
// Replays stored Morse words from RAM as timed LED pulses, one clock_1hz tick per time unit.
// Optional MORSE_PLAYBACK_REPEAT_EN: loop back to address 0 forever instead of finishing.
module morse_playback
    import morse_pkg::*;
#(
    parameter int ADDR_W         = 4,
    parameter int WORD_W         = 10,
    parameter int DASH_TICKS     = 3,
    parameter int WORD_GAP_TICKS = 3
) (
    input  logic              clock_1hz,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] word_count,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WORD_W-1:0] rd_data,
    output logic              led,
    output logic [1:0]        sym,
    output logic              busy,
    output logic              done
);

    localparam int NSYM      = WORD_W / 2;
    localparam int IDX_W     = $clog2(NSYM + 1);
    localparam int MAX_T0    = (DASH_TICKS > WORD_GAP_TICKS) ? DASH_TICKS : WORD_GAP_TICKS;
    localparam int MAX_TICKS = (MAX_T0 > DOT_TICKS) ? MAX_T0 : DOT_TICKS;
    localparam int TMR_W     = $clog2(MAX_TICKS + 1);

    localparam logic [IDX_W-1:0]  IDX_END  = IDX_W'(NSYM);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [TMR_W-1:0]  T_DOT    = TMR_W'(DOT_TICKS);
    localparam logic [TMR_W-1:0]  T_DASH   = TMR_W'(DASH_TICKS);
    localparam logic [TMR_W-1:0]  T_WGAP   = TMR_W'(WORD_GAP_TICKS);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]   wcount_q, wcount_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                led_q, led_d;
    logic [1:0]          sym_q, sym_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                tmr_load;
    logic [TMR_W-1:0]    tmr_val;
    logic [TMR_W-1:0]    tmr_value;
    logic                tmr_expired;
    logic                tmr_done;
    logic                decide;
    logic [1:0]          head_sym;
    logic [ADDR_W-1:0]   last_addr;

    tick_timer #(
        .W (TMR_W)
    ) u_timer (
        .clock_1hz (clock_1hz),
        .resetn    (resetn),
        .load      (tmr_load),
        .load_val  (tmr_val),
        .value     (tmr_value),
        .expired   (tmr_expired)
    );

    // A zero-length load behaves as a single tick rather than stalling.
    assign tmr_done  = tmr_expired || (tmr_value == '0);
    assign last_addr = wcount_q - ADDR_ONE;

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        wcount_d  = wcount_q;
        shreg_d   = shreg_q;
        idx_d     = idx_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        decide    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    wcount_d = word_count;
                    state_d  = (word_count != '0) ? ST_FETCH : ST_DONE;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                shreg_d = rd_data;
                idx_d   = '0;
                decide  = 1'b1;
            end
            ST_ON: begin
                if (tmr_done) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                shreg_d = shreg_q << 2;
                idx_d   = idx_q + IDX_ONE;
                decide  = 1'b1;
            end
            ST_WGAP: begin
                if (tmr_done) begin
                    if (rd_addr_q == last_addr) begin
`ifdef MORSE_PLAYBACK_REPEAT_EN
                        rd_addr_d = '0;
                        state_d   = ST_FETCH;
`else
                        state_d   = ST_DONE;
`endif
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_ONE;
                        state_d   = ST_FETCH;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Symbol decision works on the register contents as they will be after this edge.
        head_sym = shreg_d[WORD_W-1 -: 2];
        if (decide) begin
            tmr_load = 1'b1;
            if ((idx_d == IDX_END) || !is_pulse(head_sym)) begin
                state_d = ST_WGAP;
                tmr_val = T_WGAP;
            end else begin
                state_d = ST_ON;
                tmr_val = (head_sym == SYM_DASH) ? T_DASH : T_DOT;
            end
        end

        if (abort && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            tmr_load = 1'b1;
            tmr_val  = '0;
        end

        if (state_d == ST_IDLE) begin
            rd_addr_d = '0;
        end

        led_d  = (state_d == ST_ON);
        sym_d  = led_d ? head_sym : SYM_EMPTY;
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clock_1hz) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            rd_addr_q <= '0;
            wcount_q  <= '0;
            shreg_q   <= '0;
            idx_q     <= '0;
            led_q     <= 1'b0;
            sym_q     <= SYM_EMPTY;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            wcount_q  <= wcount_d;
            shreg_q   <= shreg_d;
            idx_q     <= idx_d;
            led_q     <= led_d;
            sym_q     <= sym_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rd_addr = rd_addr_q;
    assign led     = led_q;
    assign sym     = sym_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_morse_playback.sv
// Bench for morse_playback: hand-computed vector table, randomized words against a
// sequence-level reference model, and hand-written abort / reset corner cases.
module tb_morse_playback;

    logic       clock_1hz = 1'b0;
    logic       resetn;
    logic       start;
    logic       abort;
    logic [3:0] word_count;
    logic [3:0] rd_addr;
    logic [9:0] rd_data;
    logic       led;
    logic [1:0] sym;
    logic       busy;
    logic       done;

    logic [9:0] mem [16];

    always #5 clock_1hz = ~clock_1hz;

    always @(posedge clock_1hz) rd_data <= mem[rd_addr];

    morse_playback #(
        .ADDR_W         (4),
        .WORD_W         (10),
        .DASH_TICKS     (3),
        .WORD_GAP_TICKS (3)
    ) dut (
        .clock_1hz  (clock_1hz),
        .resetn     (resetn),
        .start      (start),
        .abort      (abort),
        .word_count (word_count),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .led        (led),
        .sym        (sym),
        .busy       (busy),
        .done       (done)
    );

    typedef struct packed {
        logic       led;
        logic [1:0] sym;
        logic       busy;
        logic       done;
        logic [3:0] addr;
    } obs_t;

    typedef struct {
        logic [9:0] w0;
        logic [9:0] w1;
        logic [9:0] fill;
        int         wc;
        int         done_c;
        int         leds;
    } vec_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic obs_t mk(input logic l, input logic [1:0] s, input logic b,
                                input logic d, input logic [3:0] a);
        obs_t o;
        o.led = l; o.sym = s; o.busy = b; o.done = d; o.addr = a;
        return o;
    endfunction

    // Expected per-cycle outputs from the cycle after start is sampled up to the first idle cycle.
    task automatic build_model(input int wc);
        logic [9:0] w;
        logic [1:0] s;
        logic [3:0] aa;
        int         dur;
        exp_q.delete();
        if (wc == 0) begin
            exp_q.push_back(mk(1'b0, 2'b00, 1'b1, 1'b1, 4'd0));
        end else begin
            for (int a = 0; a < wc; a++) begin
                aa = 4'(a);
                w  = mem[a];
                exp_q.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, aa));
                exp_q.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, aa));
                for (int i = 0; i < 5; i++) begin
                    s = w[9 - 2*i -: 2];
                    if (s == 2'b01) dur = 1;
                    else if (s == 2'b11) dur = 3;
                    else break;
                    for (int t = 0; t < dur; t++) exp_q.push_back(mk(1'b1, s, 1'b1, 1'b0, aa));
                    exp_q.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, aa));
                end
                for (int t = 0; t < 3; t++) exp_q.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, aa));
            end
            exp_q.push_back(mk(1'b0, 2'b00, 1'b1, 1'b1, 4'(wc - 1)));
        end
        exp_q.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, 4'd0));
    endtask

    task automatic play(input int wc, input bit noise, output int done_cyc, output int led_cnt);
        obs_t o;
        build_model(wc);
        done_cyc   = -1;
        led_cnt    = 0;
        word_count = 4'(wc);
        start      = 1'b1;
        @(posedge clock_1hz); #1;
        start = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            o = {led, sym, busy, done, rd_addr};
            check($sformatf("wc%0d_cyc%0d", wc, k + 1), 32'(o), 32'(exp_q[k]));
            if (o.done && done_cyc < 0) done_cyc = k + 1;
            if (o.led) led_cnt++;
            start = noise && exp_q[k].busy && ($urandom_range(0, 3) == 0);
            if (noise) word_count = 4'($urandom);
            @(posedge clock_1hz); #1;
        end
        start = 1'b0;
    endtask

    task automatic start_dash_word();
        for (int a = 0; a < 16; a++) mem[a] = 10'd0;
        mem[0]     = 10'b11_00_00_00_00;
        word_count = 4'd1;
        start      = 1'b1;
        @(posedge clock_1hz); #1;
        start = 1'b0;
        @(posedge clock_1hz); #1;
        @(posedge clock_1hz); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        int   dc, lc;

        tbl[0] = '{10'b01_11_00_00_00, 10'd0, 10'd0, 1, 12, 4};
        tbl[1] = '{10'b11_11_11_11_11, 10'd0, 10'd0, 1, 26, 15};
        tbl[2] = '{10'b01_01_00_00_00, 10'd0, 10'd0, 0, 1, 0};
        tbl[3] = '{10'b10_01_11_00_00, 10'd0, 10'd0, 1, 6, 0};
        tbl[4] = '{10'b01_00_00_00_00, 10'b11_01_00_00_00, 10'd0, 2, 19, 5};
        tbl[5] = '{10'd0, 10'd0, 10'd0, 15, 76, 0};
        tbl[6] = '{10'b01_01_01_01_01, 10'd0, 10'd0, 1, 16, 5};

        for (int a = 0; a < 16; a++) mem[a] = 10'd0;
        resetn     = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        word_count = 4'd0;
        @(posedge clock_1hz); #1;
        @(posedge clock_1hz); #1;
        check("reset_state", 32'({led, sym, busy, done, rd_addr}), 32'd0);
        resetn = 1'b1;
        @(posedge clock_1hz); #1;
        check("idle_after_reset", 32'({led, sym, busy, done, rd_addr}), 32'd0);

        for (int v = 0; v < 7; v++) begin
            for (int a = 0; a < 16; a++) mem[a] = tbl[v].fill;
            mem[0] = tbl[v].w0;
            mem[1] = tbl[v].w1;
            play(tbl[v].wc, 1'b1, dc, lc);
            check($sformatf("tbl%0d_done_cycle", v), 32'(dc), 32'(tbl[v].done_c));
            check($sformatf("tbl%0d_led_ticks", v), 32'(lc), 32'(tbl[v].leds));
        end

        for (int r = 0; r < 12; r++) begin
            for (int a = 0; a < 16; a++) begin
                for (int i = 0; i < 5; i++) mem[a][9 - 2*i -: 2] = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 2) == 0) mem[a][9:8] = 2'b11;
            end
            play(int'($urandom_range(0, 6)), 1'b1, dc, lc);
        end

        // Abort on the second tick of a dash.
        start_dash_word();
        check("abort_pre_led", 32'({led, sym}), 32'({1'b1, 2'b11}));
        @(posedge clock_1hz); #1;
        check("abort_tick2_led", 32'(led), 32'd1);
        abort = 1'b1;
        @(posedge clock_1hz); #1;
        abort = 1'b0;
        check("abort_next", 32'({led, sym, busy, done, rd_addr}), 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clock_1hz); #1;
            check($sformatf("abort_quiet%0d", c), 32'({led, busy, done}), 32'd0);
        end

        // Reset asserted while the LED is on.
        start_dash_word();
        @(posedge clock_1hz); #1;
        resetn = 1'b0;
        @(posedge clock_1hz); #1;
        check("reset_mid_on", 32'({led, sym, busy, done, rd_addr}), 32'd0);
        resetn = 1'b1;
        @(posedge clock_1hz); #1;
        check("reset_mid_on_idle", 32'({led, sym, busy, done, rd_addr}), 32'd0);

        mem[0] = 10'b01_11_00_00_00;
        play(1, 1'b0, dc, lc);
        check("recover_done_cycle", 32'(dc), 32'd12);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
